// File: rtl/cnn_layer_accel_rd_arb_if.sv
// rtl/cnn_layer_accel_rd_arb_if.sv - FAS per-ID read-request bundle plus the shared memory read channel
interface cnn_layer_accel_rd_arb_if #(
    parameter int C_NUM_RD_ID = 4,
    parameter int C_ADDR_WTH  = 32,
    parameter int C_LEN_WTH   = 16,
    parameter int C_DATA_WTH  = 512
) ();
    logic [C_NUM_RD_ID-1:0]            init_read_req;
    logic [C_NUM_RD_ID*C_ADDR_WTH-1:0] init_read_addr;
    logic [C_NUM_RD_ID*C_LEN_WTH-1:0]  init_read_len;
    logic [C_NUM_RD_ID-1:0]            init_read_req_ack;
    logic [C_NUM_RD_ID-1:0]            init_read_in_prog;
    logic [C_DATA_WTH-1:0]             init_read_data;
    logic [C_NUM_RD_ID-1:0]            init_read_data_vld;
    logic [C_NUM_RD_ID-1:0]            init_read_data_rdy;
    logic [C_NUM_RD_ID-1:0]            init_read_cmpl;

    logic                              mem_rd_req;
    logic [C_ADDR_WTH-1:0]             mem_rd_addr;
    logic [C_LEN_WTH-1:0]              mem_rd_len;
    logic                              mem_rd_req_ack;
    logic [C_DATA_WTH-1:0]             mem_rd_data;
    logic                              mem_rd_data_vld;
    logic                              mem_rd_data_rdy;

    // slave: the arbiter itself; master: the FAS requesters and memory around it
    modport slave (
        input  init_read_req, init_read_addr, init_read_len, init_read_data_rdy,
        input  mem_rd_req_ack, mem_rd_data, mem_rd_data_vld,
        output init_read_req_ack, init_read_in_prog, init_read_data, init_read_data_vld,
        output init_read_cmpl, mem_rd_req, mem_rd_addr, mem_rd_len, mem_rd_data_rdy
    );

    modport master (
        output init_read_req, init_read_addr, init_read_len, init_read_data_rdy,
        output mem_rd_req_ack, mem_rd_data, mem_rd_data_vld,
        input  init_read_req_ack, init_read_in_prog, init_read_data, init_read_data_vld,
        input  init_read_cmpl, mem_rd_req, mem_rd_addr, mem_rd_len, mem_rd_data_rdy
    );
endinterface

// File: rtl/cnn_layer_accel_rd_arb.sv
// rtl/cnn_layer_accel_rd_arb.sv - round-robin arbiter of FAS read requests onto one memory read channel
module cnn_layer_accel_rd_arb #(
    parameter int C_NUM_RD_ID = 4,
    parameter int C_ADDR_WTH  = 32,
    parameter int C_LEN_WTH   = 16,
    parameter int C_DATA_WTH  = 512
) (
    input  logic                     clk_intf,
    input  logic                     rst,
    cnn_layer_accel_rd_arb_if.slave  rd_if
);
    localparam int C_ID_WTH = (C_NUM_RD_ID > 1) ? $clog2(C_NUM_RD_ID) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_CMPL
    } state_t;

    state_t                  r_state;
    logic [C_ID_WTH-1:0]     r_id;
    logic [C_ID_WTH-1:0]     r_last_grant;
    logic [C_ADDR_WTH-1:0]   r_addr;
    logic [C_LEN_WTH-1:0]    r_len;
    logic [C_LEN_WTH-1:0]    r_cnt;
    logic [C_NUM_RD_ID-1:0]  r_req_ack;
    logic [C_NUM_RD_ID-1:0]  r_in_prog;
    logic [C_NUM_RD_ID-1:0]  r_cmpl;
    logic                    r_mem_req;

    logic [C_ADDR_WTH-1:0]   w_addr_arr [C_NUM_RD_ID];
    logic [C_LEN_WTH-1:0]    w_len_arr  [C_NUM_RD_ID];
    logic [C_ID_WTH-1:0]     w_sel_id;
    logic [C_ID_WTH-1:0]     w_cand;
    logic                    w_sel_vld;
    int                      w_idx;
    logic [C_NUM_RD_ID-1:0]  w_id_onehot;
    logic                    w_xfer;
    logic                    w_beat;
    logic                    w_last_beat;

    function automatic logic [C_NUM_RD_ID-1:0] f_onehot(input logic [C_ID_WTH-1:0] id);
        logic [C_NUM_RD_ID-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    for (genvar gi = 0; gi < C_NUM_RD_ID; gi++) begin : g_slice
        assign w_addr_arr[gi] = rd_if.init_read_addr[gi*C_ADDR_WTH +: C_ADDR_WTH];
        assign w_len_arr[gi]  = rd_if.init_read_len[gi*C_LEN_WTH +: C_LEN_WTH];
    end

    // Search starts one past the previous winner so every requester gets its turn.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_id  = '0;
        w_cand    = '0;
        w_idx     = 0;
        for (int i = 1; i <= C_NUM_RD_ID; i++) begin
            w_idx = int'(r_last_grant) + i;
            if (w_idx >= C_NUM_RD_ID) begin
                w_idx = w_idx - C_NUM_RD_ID;
            end
            w_cand = C_ID_WTH'(w_idx);
            if (!w_sel_vld && rd_if.init_read_req[w_cand]) begin
                w_sel_vld = 1'b1;
                w_sel_id  = w_cand;
            end
        end
    end

    assign w_id_onehot = f_onehot(r_id);
    assign w_xfer      = (r_state == ST_XFER);
    assign w_beat      = w_xfer && rd_if.mem_rd_data_vld && rd_if.init_read_data_rdy[r_id];
    assign w_last_beat = w_beat && (r_cnt == (r_len - C_LEN_WTH'(1)));

    always_ff @(posedge clk_intf or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_id         <= '0;
            r_last_grant <= C_ID_WTH'(C_NUM_RD_ID - 1);
            r_addr       <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_req_ack    <= '0;
            r_in_prog    <= '0;
            r_cmpl       <= '0;
            r_mem_req    <= 1'b0;
        end else begin
            r_req_ack <= '0;
            r_cmpl    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_vld) begin
                        r_id      <= w_sel_id;
                        r_addr    <= w_addr_arr[w_sel_id];
                        r_len     <= w_len_arr[w_sel_id];
                        r_req_ack <= f_onehot(w_sel_id);
                        r_in_prog <= f_onehot(w_sel_id);
                        // Zero-length reads complete without touching memory.
                        if (w_len_arr[w_sel_id] == '0) begin
                            r_cmpl  <= f_onehot(w_sel_id);
                            r_state <= ST_CMPL;
                        end else begin
                            r_mem_req <= 1'b1;
                            r_state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (rd_if.mem_rd_req_ack) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + C_LEN_WTH'(1);
                        if (w_last_beat) begin
                            r_cmpl  <= w_id_onehot;
                            r_state <= ST_CMPL;
                        end
                    end
                end
                ST_CMPL: begin
                    r_in_prog    <= '0;
                    r_last_grant <= r_id;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_if.init_read_req_ack  = r_req_ack;
    assign rd_if.init_read_in_prog  = r_in_prog;
    assign rd_if.init_read_cmpl     = r_cmpl;
    assign rd_if.mem_rd_req         = r_mem_req;
    assign rd_if.mem_rd_addr        = r_addr;
    assign rd_if.mem_rd_len         = r_len;

    // Data path is a pure pass-through while a transfer owns the channel.
    assign rd_if.init_read_data     = w_xfer ? rd_if.mem_rd_data : '0;
    assign rd_if.init_read_data_vld = (w_xfer && rd_if.mem_rd_data_vld) ? w_id_onehot : '0;
    assign rd_if.mem_rd_data_rdy    = w_xfer && rd_if.init_read_data_rdy[r_id];
endmodule

// File: tb/tb_cnn_layer_accel_rd_arb.sv
// tb/tb_cnn_layer_accel_rd_arb.sv - directed table-driven bench for cnn_layer_accel_rd_arb
module tb_cnn_layer_accel_rd_arb;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int DW = 512;

    logic clk_intf = 1'b0;
    logic rst;
    always #5 clk_intf = ~clk_intf;

    cnn_layer_accel_rd_arb_if #(.C_NUM_RD_ID(N), .C_ADDR_WTH(AW), .C_LEN_WTH(LW), .C_DATA_WTH(DW)) rd_if ();

    cnn_layer_accel_rd_arb #(.C_NUM_RD_ID(N), .C_ADDR_WTH(AW), .C_LEN_WTH(LW), .C_DATA_WTH(DW)) dut (
        .clk_intf (clk_intf),
        .rst      (rst),
        .rd_if    (rd_if)
    );

    typedef struct {
        logic [N-1:0]  req;
        int            id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            ack_dly;
        logic [7:0]    rdy_pat;
    } vec_t;

    vec_t vecs [11];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int k);
        logic [31:0] w;
        w = 32'h5A5A_0000 + 32'(k);
        return {{15{w}}, 32'hA0 + 32'(k)};
    endfunction

    task automatic set_slices(input int id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        for (int i = 0; i < N; i++) begin
            rd_if.init_read_addr[i*AW +: AW] = (i == id) ? addr : (32'hDEAD_0000 + 32'(i));
            rd_if.init_read_len[i*LW +: LW]  = (i == id) ? len  : (16'd7 + 16'(i));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"},    rd_if.init_read_req_ack, '0);
        chk({tag, "_inprog"}, rd_if.init_read_in_prog, '0);
        chk({tag, "_cmpl"},   rd_if.init_read_cmpl, '0);
        chk({tag, "_vld"},    rd_if.init_read_data_vld, '0);
        chk({tag, "_data"},   rd_if.init_read_data, '0);
        chk({tag, "_memreq"}, rd_if.mem_rd_req, '0);
        chk({tag, "_memrdy"}, rd_if.mem_rd_data_rdy, '0);
        chk({tag, "_addr"},   rd_if.mem_rd_addr, '0);
        chk({tag, "_len"},    rd_if.mem_rd_len, '0);
    endtask

    // One full transaction: grant, memory request, beats, completion, turnaround.
    task automatic run_txn(input vec_t v);
        logic [N-1:0] exp_oh;
        logic [7:0]   pat;
        logic         rdy_b;
        bit           got_ack, done, mem_hs, ack_drv, mem_req_seen, drv_vld;
        int           ack_t, last_beat_t, req_cnt, beats, pidx;
        exp_oh = N'(1) << v.id;
        pat    = v.rdy_pat;
        got_ack = 0; done = 0; mem_hs = 0; ack_drv = 0; mem_req_seen = 0;
        ack_t = -1; last_beat_t = -10; req_cnt = 0; beats = 0; pidx = 0;
        set_slices(v.id, v.addr, v.len);
        rd_if.init_read_req = v.req;
        for (int t = 0; t < 400 && !done; t++) begin
            @(posedge clk_intf); #1;
            if (ack_drv) mem_hs = 1;
            ack_drv = 0;
            if (!got_ack) begin
                if (rd_if.init_read_req_ack != '0) begin
                    chk("grant_id", rd_if.init_read_req_ack, exp_oh);
                    got_ack = 1;
                    ack_t   = t;
                    rd_if.init_read_req = rd_if.init_read_req & ~exp_oh;
                end
            end else begin
                chk("ack_single_pulse", rd_if.init_read_req_ack, '0);
            end
            if (got_ack && t > ack_t) chk("in_prog", rd_if.init_read_in_prog, exp_oh);
            if (rd_if.init_read_cmpl != '0) begin
                chk("cmpl_id", rd_if.init_read_cmpl, exp_oh);
                chk("beat_count", beats, v.len);
                chk("cmpl_after_ack", got_ack, 1'b1);
                if (v.len != '0) chk("cmpl_timing", t, last_beat_t + 1);
                done = 1;
            end
            rd_if.mem_rd_req_ack = 1'b0;
            if (mem_hs) begin
                chk("mem_req_dropped", rd_if.mem_rd_req, 1'b0);
            end else if (rd_if.mem_rd_req) begin
                mem_req_seen = 1;
                chk("mem_addr", rd_if.mem_rd_addr, v.addr);
                chk("mem_len", rd_if.mem_rd_len, v.len);
                req_cnt++;
                if (req_cnt > v.ack_dly) begin
                    rd_if.mem_rd_req_ack = 1'b1;
                    ack_drv = 1;
                end
            end
            drv_vld = mem_hs && (beats < int'(v.len));
            if (drv_vld) begin
                rd_if.mem_rd_data_vld = 1'b1;
                rd_if.mem_rd_data     = beat(beats);
                rdy_b = pat[3'(pidx)];
                pidx++;
            end else begin
                rd_if.mem_rd_data_vld = 1'b0;
                rd_if.mem_rd_data     = '0;
                rdy_b = 1'b0;
            end
            rd_if.init_read_data_rdy = ~exp_oh | (rdy_b ? exp_oh : '0);
            #1;
            if (drv_vld) begin
                chk("beat_vld", rd_if.init_read_data_vld, exp_oh);
                chk("beat_rdy_mirror", rd_if.mem_rd_data_rdy, rdy_b);
                chk("beat_data", rd_if.init_read_data, beat(beats));
                if (rdy_b) begin
                    beats++;
                    last_beat_t = t;
                end
            end else begin
                chk("quiet_vld", rd_if.init_read_data_vld, '0);
                chk("quiet_rdy", rd_if.mem_rd_data_rdy, 1'b0);
                chk("quiet_data", rd_if.init_read_data, '0);
            end
        end
        chk("txn_done", done, 1'b1);
        chk("mem_req_issued", mem_req_seen, v.len != '0);
        rd_if.mem_rd_data_vld    = 1'b0;
        rd_if.mem_rd_req_ack     = 1'b0;
        rd_if.init_read_data_rdy = '0;
        @(posedge clk_intf); #1;
        chk("post_in_prog", rd_if.init_read_in_prog, '0);
        chk("post_cmpl", rd_if.init_read_cmpl, '0);
        chk("post_ack", rd_if.init_read_req_ack, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit got;
        vecs[0]  = '{4'b0101, 0, 32'h0000_0100, 16'd2, 1, 8'hFF};
        vecs[1]  = '{4'b0100, 2, 32'h0000_0300, 16'd2, 0, 8'hFF};
        vecs[2]  = '{4'b0101, 0, 32'h0000_0140, 16'd2, 1, 8'hFF};
        vecs[3]  = '{4'b0100, 2, 32'h0000_0340, 16'd2, 0, 8'hFF};
        vecs[4]  = '{4'b0010, 1, 32'h0000_1000, 16'd4, 2, 8'hFF};
        vecs[5]  = '{4'b1000, 3, 32'h0000_4000, 16'd3, 1, 8'h19};
        vecs[6]  = '{4'b1000, 3, 32'h0000_5000, 16'd0, 0, 8'hFF};
        vecs[7]  = '{4'b1111, 0, 32'h0000_6000, 16'd1, 0, 8'hFF};
        vecs[8]  = '{4'b0011, 1, 32'h0000_2000, 16'd3, 1, 8'hFF};
        vecs[9]  = '{4'b0001, 0, 32'h0000_2100, 16'd2, 0, 8'hAA};
        vecs[10] = '{4'b0100, 2, 32'hFFFF_FFC0, 16'd5, 3, 8'hED};

        rst = 1'b1;
        rd_if.init_read_req      = '0;
        rd_if.init_read_addr     = '0;
        rd_if.init_read_len      = '0;
        rd_if.init_read_data_rdy = '0;
        rd_if.mem_rd_req_ack     = 1'b0;
        rd_if.mem_rd_data        = '0;
        rd_if.mem_rd_data_vld    = 1'b0;
        repeat (3) @(posedge clk_intf);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_txn(vecs[i]);

        // Reset during the second beat of an 8-beat ID0 read.
        set_slices(0, 32'h0000_3000, 16'd8);
        rd_if.init_read_req = 4'b0001;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(posedge clk_intf); #1;
            if (rd_if.init_read_req_ack != '0) got = 1;
        end
        chk("rst_seq_grant", got, 1'b1);
        rd_if.init_read_req = '0;
        chk("rst_seq_memreq", rd_if.mem_rd_req, 1'b1);
        rd_if.mem_rd_req_ack = 1'b1;
        @(posedge clk_intf); #1;
        rd_if.mem_rd_req_ack     = 1'b0;
        rd_if.mem_rd_data_vld    = 1'b1;
        rd_if.mem_rd_data        = beat(0);
        rd_if.init_read_data_rdy = 4'b0001;
        @(posedge clk_intf); #1;
        rd_if.mem_rd_data = beat(1);
        #1;
        chk("rst_seq_beat2_vld", rd_if.init_read_data_vld, 4'b0001);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(negedge clk_intf);
        rst = 1'b0;
        rd_if.mem_rd_data_vld    = 1'b0;
        rd_if.mem_rd_data        = '0;
        rd_if.init_read_data_rdy = '0;
        run_txn('{4'b0001, 0, 32'h0000_3100, 16'd2, 1, 8'hFF});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
